tl_ul_mem_responder: RTL and testbench

- TileLink-UL responder (slave) that answers the A/D channel traffic issued by the core-side memory ports: accepts Get/PutFull/PutPartial on channel A and returns AccessAckData/AccessAck on channel D.
- Backed by a word-addressed on-chip RAM with fixed pipeline latency and a bounded response queue, so D-channel backpressure is absorbed without loss.
- Used as a simulation and FPGA memory model behind each imem/dmem lane.

---
 rtl/tl_ul_mem_responder_if.sv | 43 ++++
 rtl/tl_ul_mem_responder.sv | 188 ++++++++++++++++++
 tb/tb_tl_ul_mem_responder.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tl_ul_mem_responder_if.sv
// TileLink-UL A/D channel bundle between a core-side memory port (master) and a responder (slave).
interface tl_ul_mem_responder_if #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int SOURCE_WIDTH = 10,
    parameter int SIZE_WIDTH   = 4
);
    logic                      a_valid;
    logic                      a_ready;
    logic [2:0]                a_bits_opcode;
    logic [2:0]                a_bits_param;
    logic [SIZE_WIDTH-1:0]     a_bits_size;
    logic [SOURCE_WIDTH-1:0]   a_bits_source;
    logic [ADDR_WIDTH-1:0]     a_bits_address;
    logic [DATA_WIDTH/8-1:0]   a_bits_mask;
    logic [DATA_WIDTH-1:0]     a_bits_data;
    logic                      a_bits_corrupt;

    logic                      d_valid;
    logic                      d_ready;
    logic [2:0]                d_bits_opcode;
    logic [1:0]                d_bits_param;
    logic [SIZE_WIDTH-1:0]     d_bits_size;
    logic [SOURCE_WIDTH-1:0]   d_bits_source;
    logic [2:0]                d_bits_sink;
    logic                      d_bits_denied;
    logic [DATA_WIDTH-1:0]     d_bits_data;
    logic                      d_bits_corrupt;

    modport master (
        output a_valid, a_bits_opcode, a_bits_param, a_bits_size, a_bits_source,
               a_bits_address, a_bits_mask, a_bits_data, a_bits_corrupt, d_ready,
        input  a_ready, d_valid, d_bits_opcode, d_bits_param, d_bits_size, d_bits_source,
               d_bits_sink, d_bits_denied, d_bits_data, d_bits_corrupt
    );

    modport slave (
        input  a_valid, a_bits_opcode, a_bits_param, a_bits_size, a_bits_source,
               a_bits_address, a_bits_mask, a_bits_data, a_bits_corrupt, d_ready,
        output a_ready, d_valid, d_bits_opcode, d_bits_param, d_bits_size, d_bits_source,
               d_bits_sink, d_bits_denied, d_bits_data, d_bits_corrupt
    );
endinterface

// File: rtl/tl_ul_mem_responder.sv
// TileLink-UL memory responder: word RAM, fixed-latency response pipeline, credit-limited response FIFO.
// Optional macro TL_RESP_RANDOM_STALL_EN adds LFSR-driven A/D stalls for stress testing.
module tl_ul_mem_responder #(
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    ADDR_WIDTH   = 32,
    parameter int                    SOURCE_WIDTH = 10,
    parameter int                    SIZE_WIDTH   = 4,
    parameter int                    MEM_WORDS    = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = '0,
    parameter int                    LATENCY      = 2,
    parameter int                    RSP_DEPTH    = 4
) (
    input  logic                   clock,
    input  logic                   reset_n,
    tl_ul_mem_responder_if.slave   tl
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int OFF_W = $clog2(BYTES);
    localparam int IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int CNT_W = $clog2(RSP_DEPTH + 1);
    localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

    typedef struct packed {
        logic                    use_ram;
        logic [2:0]              opcode;
        logic                    denied;
        logic                    corrupt;
        logic [SIZE_WIDTH-1:0]   size;
        logic [SOURCE_WIDTH-1:0] source;
        logic [DATA_WIDTH-1:0]   data;
    } rsp_t;

    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

    logic                  a_fire, d_fire, a_stall, d_stall;
    logic [ADDR_WIDTH-1:0] offset, word_index;
    logic [IDX_W-1:0]      mem_idx;
    logic                  in_range, is_get, is_put;
    logic [BYTES-1:0]      byte_we;
    rsp_t                  a_rsp, fifo_in, d_head;
    logic                  fifo_push, fifo_empty;
    logic                  run_reg;
    logic [CNT_W-1:0]      outstanding_reg, fifo_cnt_reg;
    logic [PTR_W-1:0]      wr_ptr_reg, rd_ptr_reg;
    rsp_t                  fifo_mem [RSP_DEPTH];
    logic                  unused_bits;

    assign unused_bits = ^tl.a_bits_param;

    // Request decode; low address bits below word alignment fall out of the shift.
    always_comb begin
        offset     = tl.a_bits_address - BASE_ADDR;
        word_index = offset >> OFF_W;
        mem_idx    = word_index[IDX_W-1:0];
        in_range   = (tl.a_bits_address >= BASE_ADDR) && (word_index < ADDR_WIDTH'(MEM_WORDS));
        is_get     = (tl.a_bits_opcode == 3'd4);
        is_put     = (tl.a_bits_opcode == 3'd0) || (tl.a_bits_opcode == 3'd1);
        a_rsp        = '0;
        a_rsp.size   = tl.a_bits_size;
        a_rsp.source = tl.a_bits_source;
        if (is_get) begin
            a_rsp.opcode = 3'd1;
            if (in_range) begin
                a_rsp.use_ram = 1'b1;
            end else begin
                a_rsp.denied  = 1'b1;
                a_rsp.corrupt = 1'b1;
            end
        end else if (is_put) begin
            a_rsp.denied = !in_range;
        end else begin
            a_rsp.denied = 1'b1;
        end
    end

    assign a_fire = tl.a_valid && tl.a_ready;
    assign d_fire = tl.d_valid && tl.d_ready;

    genvar gi;
    for (gi = 0; gi < BYTES; gi++) begin : g_byte_we
        assign byte_we[gi] = a_fire && is_put && in_range && !tl.a_bits_corrupt && tl.a_bits_mask[gi];
    end

    always_ff @(posedge clock) begin
        for (int b = 0; b < BYTES; b++) begin
            if (byte_we[b]) mem[mem_idx][8*b +: 8] <= tl.a_bits_data[8*b +: 8];
        end
    end

    if (LATENCY == 1) begin : g_lat1
        // No room for a registered read: the word is fetched combinationally into the FIFO.
        always_comb begin
            fifo_in = a_rsp;
            if (a_rsp.use_ram) fifo_in.data = mem[mem_idx];
        end
        assign fifo_push = a_fire;
    end else begin : g_pipe
        logic [DATA_WIDTH-1:0] ram_rdata_reg;
        logic [LATENCY-1:1]    st_valid_reg;
        rsp_t                  st_reg [1:LATENCY-1];
        rsp_t                  st1_resolved;

        always_ff @(posedge clock) begin
            if (a_fire) ram_rdata_reg <= mem[mem_idx];
        end

        always_comb begin
            st1_resolved = st_reg[1];
            if (st_reg[1].use_ram) st1_resolved.data = ram_rdata_reg;
        end

        // Stage 1 is aligned with the RAM read register; read data is merged on leaving it.
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                st_valid_reg <= '0;
                for (int k = 1; k < LATENCY; k++) st_reg[k] <= '0;
            end else begin
                st_valid_reg[1] <= a_fire;
                st_reg[1]       <= a_rsp;
                for (int k = 2; k < LATENCY; k++) begin
                    st_valid_reg[k] <= st_valid_reg[k-1];
                    st_reg[k]       <= (k == 2) ? st1_resolved : st_reg[k-1];
                end
            end
        end

        assign fifo_in   = (LATENCY == 2) ? st1_resolved : st_reg[LATENCY-1];
        assign fifo_push = st_valid_reg[LATENCY-1];
    end

`ifdef TL_RESP_RANDOM_STALL_EN
    logic [15:0] lfsr_reg;
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) lfsr_reg <= 16'hACE1;
        else          lfsr_reg <= {lfsr_reg[14:0], lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10]};
    end
    assign a_stall = lfsr_reg[0];
    assign d_stall = lfsr_reg[1];
`else
    assign a_stall = 1'b0;
    assign d_stall = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (fifo_push) fifo_mem[wr_ptr_reg] <= fifo_in;
    end

    // Credits cover pipeline plus FIFO, so the FIFO can never be pushed while full.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            run_reg         <= 1'b0;
            outstanding_reg <= '0;
            fifo_cnt_reg    <= '0;
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
        end else begin
            run_reg <= 1'b1;
            case ({a_fire, d_fire})
                2'b10:   outstanding_reg <= outstanding_reg + CNT_W'(1);
                2'b01:   outstanding_reg <= outstanding_reg - CNT_W'(1);
                default: ;
            endcase
            case ({fifo_push, d_fire})
                2'b10:   fifo_cnt_reg <= fifo_cnt_reg + CNT_W'(1);
                2'b01:   fifo_cnt_reg <= fifo_cnt_reg - CNT_W'(1);
                default: ;
            endcase
            if (fifo_push)
                wr_ptr_reg <= (wr_ptr_reg == PTR_W'(RSP_DEPTH - 1)) ? '0 : wr_ptr_reg + PTR_W'(1);
            if (d_fire)
                rd_ptr_reg <= (rd_ptr_reg == PTR_W'(RSP_DEPTH - 1)) ? '0 : rd_ptr_reg + PTR_W'(1);
        end
    end

    assign fifo_empty = (fifo_cnt_reg == '0);
    assign d_head     = fifo_empty ? '0 : fifo_mem[rd_ptr_reg];

    assign tl.a_ready        = run_reg && (outstanding_reg < CNT_W'(RSP_DEPTH)) && !a_stall;
    assign tl.d_valid        = !fifo_empty && !d_stall;
    assign tl.d_bits_opcode  = d_head.opcode;
    assign tl.d_bits_param   = 2'd0;
    assign tl.d_bits_size    = d_head.size;
    assign tl.d_bits_source  = d_head.source;
    assign tl.d_bits_sink    = 3'd0;
    assign tl.d_bits_denied  = d_head.denied;
    assign tl.d_bits_data    = d_head.data;
    assign tl.d_bits_corrupt = d_head.corrupt;
endmodule

// File: tb/tb_tl_ul_mem_responder.sv
// Scoreboard bench for tl_ul_mem_responder: reference model predicts each D beat at A acceptance.
module tb_tl_ul_mem_responder;
    localparam int          DW    = 32;
    localparam int          AW    = 32;
    localparam int          SRCW  = 10;
    localparam int          SZW   = 4;
    localparam int          WORDS = 1024;
    localparam logic [31:0] BASE  = 32'h0;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    tl_ul_mem_responder_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SOURCE_WIDTH(SRCW), .SIZE_WIDTH(SZW)) tl_bus ();

    tl_ul_mem_responder #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SOURCE_WIDTH(SRCW), .SIZE_WIDTH(SZW),
        .MEM_WORDS(WORDS), .BASE_ADDR(BASE), .LATENCY(2), .RSP_DEPTH(4)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .tl      (tl_bus)
    );

    typedef struct {
        logic [2:0]      opcode;
        logic            denied;
        logic            corrupt;
        logic [SZW-1:0]  size;
        logic [SRCW-1:0] source;
        logic [DW-1:0]   data;
    } exp_t;

    exp_t        exp_q [$];
    logic [31:0] ref_mem [WORDS];
    int          checks = 0;
    int          errors = 0;
    int          d_mode = 0;
    int          txn    = 0;

    // Reference: TileLink-UL access semantics applied directly to a word array.
    function automatic exp_t ref_model(input logic [2:0] op, input logic [31:0] addr, input logic [3:0] mask,
                                       input logic [31:0] data, input logic corr,
                                       input logic [SZW-1:0] size, input logic [SRCW-1:0] src);
        exp_t r;
        int unsigned idx;
        bit in_range;
        r = '{opcode: 3'd0, denied: 1'b0, corrupt: 1'b0, size: size, source: src, data: 32'd0};
        idx = (addr - BASE) / (DW / 8);
        in_range = (addr >= BASE) && (idx < WORDS);
        if (op == 3'd4) begin
            r.opcode = 3'd1;
            if (in_range) r.data = ref_mem[idx];
            else begin r.denied = 1'b1; r.corrupt = 1'b1; end
        end else if (op == 3'd0 || op == 3'd1) begin
            if (!in_range) r.denied = 1'b1;
            else if (!corr) begin
                for (int b = 0; b < 4; b++)
                    if (mask[b]) ref_mem[idx][8*b +: 8] = data[8*b +: 8];
            end
        end else begin
            r.denied = 1'b1;
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic send(input logic [2:0] op, input logic [31:0] addr, input logic [3:0] mask,
                        input logic [31:0] data, input logic corr, input logic [SRCW-1:0] src,
                        input logic [SZW-1:0] size);
        int  waited = 0;
        bit  done = 0;
        tl_bus.a_valid        = 1'b1;
        tl_bus.a_bits_opcode  = op;
        tl_bus.a_bits_param   = 3'($urandom_range(0, 7));
        tl_bus.a_bits_size    = size;
        tl_bus.a_bits_source  = src;
        tl_bus.a_bits_address = addr;
        tl_bus.a_bits_mask    = mask;
        tl_bus.a_bits_data    = data;
        tl_bus.a_bits_corrupt = corr;
        while (!done) begin
            @(negedge clock);
            if (tl_bus.a_ready === 1'b1) begin
                exp_q.push_back(ref_model(op, addr, mask, data, corr, size, src));
                done = 1;
            end else if (++waited > 200) begin
                checks++;
                errors++;
                $display("FAIL a_accept_timeout actual=a_ready_low required=accept src=%0d", src);
                done = 1;
            end
            @(posedge clock);
            #1;
        end
        tl_bus.a_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 1000) begin
            @(negedge clock);
            n++;
        end
        check("drain_pending", exp_q.size(), 0);
        @(posedge clock);
        #1;
    endtask

    initial begin : d_ready_drv
        tl_bus.d_ready = 1'b0;
        forever begin
            @(posedge clock);
            #2;
            case (d_mode)
                0:       tl_bus.d_ready = 1'b1;
                1:       tl_bus.d_ready = 1'b0;
                default: tl_bus.d_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clock);
            if (reset_n === 1'b1 && tl_bus.d_valid === 1'b1 && tl_bus.d_ready === 1'b1) begin
                checks++;
                txn++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL d_unexpected actual=beat src=%0d required=no_beat", tl_bus.d_bits_source);
                end else begin
                    e = exp_q.pop_front();
                    if (tl_bus.d_bits_opcode !== e.opcode || tl_bus.d_bits_denied !== e.denied ||
                        tl_bus.d_bits_corrupt !== e.corrupt || tl_bus.d_bits_size !== e.size ||
                        tl_bus.d_bits_source !== e.source || tl_bus.d_bits_data !== e.data ||
                        tl_bus.d_bits_param !== 2'd0 || tl_bus.d_bits_sink !== 3'd0) begin
                        errors++;
                        $display("FAIL d_beat actual=op%0d den%0d cor%0d sz%0d src%0d data%08h par%0d snk%0d required=op%0d den%0d cor%0d sz%0d src%0d data%08h par0 snk0",
                                 tl_bus.d_bits_opcode, tl_bus.d_bits_denied, tl_bus.d_bits_corrupt,
                                 tl_bus.d_bits_size, tl_bus.d_bits_source, tl_bus.d_bits_data,
                                 tl_bus.d_bits_param, tl_bus.d_bits_sink,
                                 e.opcode, e.denied, e.corrupt, e.size, e.source, e.data);
                    end
                end
                $display("txn %0d src=%0d op=%0d den=%0d cor=%0d data=%08h", txn, tl_bus.d_bits_source,
                         tl_bus.d_bits_opcode, tl_bus.d_bits_denied, tl_bus.d_bits_corrupt, tl_bus.d_bits_data);
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [31:0] addr;
        int          r;
        tl_bus.a_valid        = 1'b0;
        tl_bus.a_bits_opcode  = '0;
        tl_bus.a_bits_param   = '0;
        tl_bus.a_bits_size    = '0;
        tl_bus.a_bits_source  = '0;
        tl_bus.a_bits_address = '0;
        tl_bus.a_bits_mask    = '0;
        tl_bus.a_bits_data    = '0;
        tl_bus.a_bits_corrupt = 1'b0;

        repeat (3) @(posedge clock);
        #1;
        check("rst_a_ready", tl_bus.a_ready, 0);
        check("rst_d_valid", tl_bus.d_valid, 0);
        check("rst_d_opcode", tl_bus.d_bits_opcode, 0);
        check("rst_d_source", tl_bus.d_bits_source, 0);
        check("rst_d_data", tl_bus.d_bits_data, 0);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        check("a_ready_after_reset", tl_bus.a_ready, 1);

        for (int w = 0; w < 8; w++) send(3'd0, w * 4, 4'hF, $urandom, 1'b0, SRCW'(w), 4'd2);
        drain();

        // Directed sequence from the block's usage examples.
        send(3'd0, 32'h10, 4'hF, 32'hDEADBEEF, 1'b0, 10'd5, 4'd2);
`ifndef TL_RESP_RANDOM_STALL_EN
        @(negedge clock);
        check("latency_early_d_valid", tl_bus.d_valid, 0);
        @(negedge clock);
        check("latency_exact_d_valid", tl_bus.d_valid, 1);
        @(posedge clock);
        #1;
`endif
        send(3'd4, 32'h10, 4'hF, 32'h0, 1'b0, 10'd6, 4'd2);
        send(3'd1, 32'h10, 4'b0101, 32'h11223344, 1'b0, 10'd7, 4'd2);
        send(3'd4, 32'h12, 4'hF, 32'h0, 1'b0, 10'd8, 4'd2);
        send(3'd4, 32'h1000, 4'hF, 32'h0, 1'b0, 10'd9, 4'd2);
        send(3'd0, 32'h1000, 4'hF, 32'hCAFEF00D, 1'b0, 10'd10, 4'd2);
        send(3'd4, 32'h0, 4'hF, 32'h0, 1'b0, 10'd11, 4'd2);
        send(3'd2, 32'h10, 4'hF, 32'h55AA55AA, 1'b0, 10'd12, 4'd2);
        send(3'd0, 32'h10, 4'hF, 32'h99999999, 1'b1, 10'd13, 4'd2);
        send(3'd4, 32'h10, 4'hF, 32'h0, 1'b0, 10'd14, 4'd2);
        drain();

        // Credit limit: four outstanding Gets with D stalled.
        d_mode = 1;
        for (int s = 0; s < 4; s++) send(3'd4, 32'h10, 4'hF, 32'h0, 1'b0, SRCW'(s), 4'd2);
        tl_bus.a_valid        = 1'b1;
        tl_bus.a_bits_opcode  = 3'd4;
        tl_bus.a_bits_source  = 10'd4;
        repeat (3) begin
            @(negedge clock);
            check("credit_full_a_ready", tl_bus.a_ready, 0);
            check("stall_head_source", tl_bus.d_bits_source, 0);
        end
        @(posedge clock);
        #1;
        d_mode = 0;
        send(3'd4, 32'h10, 4'hF, 32'h0, 1'b0, 10'd4, 4'd2);
        send(3'd4, 32'h10, 4'hF, 32'h0, 1'b0, 10'd5, 4'd2);
        drain();

        // Reset with requests in flight; earlier RAM writes must survive.
        d_mode = 1;
        send(3'd4, 32'h10, 4'hF, 32'h0, 1'b0, 10'd20, 4'd2);
        send(3'd4, 32'h04, 4'hF, 32'h0, 1'b0, 10'd21, 4'd2);
        send(3'd4, 32'h08, 4'hF, 32'h0, 1'b0, 10'd22, 4'd2);
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst_a_ready", tl_bus.a_ready, 0);
        check("midrst_d_valid", tl_bus.d_valid, 0);
        check("midrst_d_data", tl_bus.d_bits_data, 0);
        exp_q.delete();
        d_mode = 0;
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        check("postrst_a_ready", tl_bus.a_ready, 1);
        repeat (4) begin
            @(negedge clock);
            check("postrst_no_stale_d", tl_bus.d_valid, 0);
        end
        @(posedge clock);
        #1;
        send(3'd4, 32'h10, 4'hF, 32'h0, 1'b0, 10'd23, 4'd2);
        drain();

        // Randomized traffic with random D backpressure.
        d_mode = 2;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 4) == 0)
                addr = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC : 32'((WORDS + $urandom_range(0, 15)) * 4);
            else
                addr = 32'($urandom_range(0, 7) * 4 + $urandom_range(0, 3));
            r = $urandom_range(0, 9);
            if (r < 4)      send(3'd4, addr, 4'hF, $urandom, 1'b0, SRCW'(i), SZW'($urandom_range(0, 2)));
            else if (r < 6) send(3'd0, addr, 4'hF, $urandom, ($urandom_range(0, 7) == 0), SRCW'(i), 4'd2);
            else if (r < 8) send(3'd1, addr, 4'($urandom), $urandom, ($urandom_range(0, 7) == 0), SRCW'(i),
                                 SZW'($urandom_range(0, 2)));
            else            send(3'($urandom_range(2, 3) == 2 ? 2 : $urandom_range(5, 7)), addr, 4'hF, $urandom,
                                 1'b0, SRCW'(i), 4'd2);
            repeat ($urandom_range(0, 1)) begin
                @(posedge clock);
                #1;
            end
        end
        drain();
        @(negedge clock);
        check("final_a_ready", tl_bus.a_ready, 1);
        check("final_d_valid", tl_bus.d_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
